// File: rtl/ob_drain_streamer.sv
// Drains result rows from the output buffer SRAM onto a valid/ready stream; first row 3 cycles after launch, then 1/cycle.
// Backpressure: reads are credit-limited by the prefetch FIFO, so a stalled consumer never loses or duplicates a row.
module ob_drain_streamer #(
    parameter int WIDTH      = 8,
    parameter int COL        = 4,
    parameter int O_SIZE     = 256,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          start_i,
    input  logic [$clog2(O_SIZE)-1:0]     base_addr_i,
    input  logic [$clog2(O_SIZE):0]       num_rows_i,
    output logic                          ob_mem_cenb_o,
    output logic                          ob_mem_wenb_o,
    output logic [$clog2(O_SIZE)-1:0]     ob_mem_addr_o,
    input  logic [COL*WIDTH-1:0]          ob_mem_data_i,
    output logic [COL-1:0][WIDTH-1:0]     out_data_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic                          out_last_o,
    output logic                          busy_o,
    output logic                          done_o
);
    localparam int AW   = $clog2(O_SIZE);
    localparam int NW   = AW + 1;
    localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = PW + 1;
    localparam int CW   = PW + 2;
    localparam int DW   = COL * WIDTH;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIN = 2'd2} state_t;

    state_t          r_state;
    logic            r_start_q;
    logic            r_inflight;
    logic            r_busy;
    logic            r_done;
    logic [AW-1:0]   r_rd_addr;
    logic [AW-1:0]   r_addr;
    logic [NW-1:0]   r_rd_left;
    logic [NW-1:0]   r_acc_left;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CNTW-1:0] r_count;
    logic [DW-1:0]   r_fifo [FIFO_DEPTH];

    logic            w_launch;
    logic            w_vld;
    logic            w_pop;
    logic            w_issue;
    logic [CW-1:0]   w_credit;
    logic [AW-1:0]   w_rd_addr_nxt;

    assign w_launch = start_i & ~r_start_q & (r_state == S_IDLE);
    assign w_vld    = (r_count != '0);
    assign w_pop    = w_vld & out_ready_i;

    // A slot vacated by this cycle's pop is free in time for the data arriving next cycle.
    assign w_credit = CW'(r_count) + CW'(r_inflight) - CW'(w_pop);
    assign w_issue  = (r_state == S_RUN) && (r_rd_left != '0) && (w_credit < CW'(FIFO_DEPTH));
    assign w_rd_addr_nxt = (r_rd_addr == AW'(O_SIZE - 1)) ? '0 : r_rd_addr + AW'(1);

    assign ob_mem_cenb_o = ~w_issue;
    assign ob_mem_wenb_o = 1'b1;
    assign ob_mem_addr_o = w_issue ? r_rd_addr : r_addr;
    assign out_data_o    = r_fifo[r_rptr];
    assign out_valid_o   = w_vld;
    assign out_last_o    = w_vld && (r_acc_left == NW'(1));
    assign busy_o        = r_busy;
    assign done_o        = r_done;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_IDLE;
            r_start_q  <= 1'b0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_addr  <= '0;
            r_addr     <= '0;
            r_rd_left  <= '0;
            r_acc_left <= '0;
        end else begin
            r_start_q  <= start_i;
            r_inflight <= w_issue;
            r_done     <= 1'b0;
            if (w_issue) begin
                r_addr    <= r_rd_addr;
                r_rd_addr <= w_rd_addr_nxt;
                r_rd_left <= r_rd_left - NW'(1);
            end
            if (w_pop) begin
                r_acc_left <= r_acc_left - NW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_rd_addr  <= base_addr_i;
                        r_rd_left  <= num_rows_i;
                        r_acc_left <= num_rows_i;
                        r_busy     <= 1'b1;
                        r_state    <= (num_rows_i == '0) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_pop && (r_acc_left == NW'(1))) begin
                        r_state <= S_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    // Empty drains arrive here still busy and pulse done on the way out.
                    if (r_busy) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (r_inflight) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CNTW'(r_inflight) - CNTW'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_inflight) begin
            r_fifo[r_wptr] <= ob_mem_data_i;
        end
    end
endmodule

// File: tb/tb_ob_drain_streamer.sv
module tb_ob_drain_streamer;
    localparam int FD = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic [7:0]  base = '0;
    logic [8:0]  num = '0;
    logic        cenb, wenb, valid, last, busy, done;
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic [31:0] odata;
    logic [31:0] sram [256];

    int n_tests = 0;
    int n_fail  = 0;
    int o_iss   = 0;
    int o_acc   = 0;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } row_t;
    row_t       exp_q[$];
    logic [7:0] exp_addr_q[$];

    ob_drain_streamer #(.WIDTH(8), .COL(4), .O_SIZE(256), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start),
        .base_addr_i(base), .num_rows_i(num),
        .ob_mem_cenb_o(cenb), .ob_mem_wenb_o(wenb), .ob_mem_addr_o(addr),
        .ob_mem_data_i(rdata),
        .out_data_o(odata), .out_valid_o(valid), .out_ready_i(ready),
        .out_last_o(last), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!cenb) rdata <= sram[addr];

    // Scoreboard monitor: read order, row data/last, stall stability, outstanding bound.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    always @(negedge clk) begin
        if (!rstn) begin
            o_iss = 0; o_acc = 0; prev_stall = 1'b0;
        end else begin
            if (busy) begin
                n_tests++;
                if (o_iss - o_acc > FD) begin
                    n_fail++;
                    $display("FAIL outstanding: got %0d want <= %0d", o_iss - o_acc, FD);
                end
            end
            if (!cenb) begin
                n_tests++;
                if (exp_addr_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL read_addr: unexpected read of %0d", addr);
                end else begin
                    logic [7:0] ea;
                    ea = exp_addr_q.pop_front();
                    if (addr !== ea) begin
                        n_fail++;
                        $display("FAIL read_addr: got %0d want %0d", addr, ea);
                    end
                end
            end
            if (prev_stall) begin
                n_tests++;
                if (valid !== 1'b1 || odata !== prev_d || last !== prev_l) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                             valid, odata, last, prev_d, prev_l);
                end
            end
            if (valid && ready) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL row: unexpected row %h", odata);
                end else begin
                    row_t er;
                    er = exp_q.pop_front();
                    if (odata !== er.d || last !== er.l) begin
                        n_fail++;
                        $display("FAIL row: got d=%h l=%b want d=%h l=%b", odata, last, er.d, er.l);
                    end
                end
                o_acc++;
            end
            if (!cenb) o_iss++;
            prev_stall = valid && !ready;
            prev_d = odata;
            prev_l = last;
        end
    end

    task automatic launch(input logic [7:0] b, input logic [8:0] n);
        row_t r;
        @(posedge clk); #1;
        base = b; num = n; start = 1'b1;
        for (int i = 0; i < int'(n); i++) begin
            exp_addr_q.push_back(8'(int'(b) + i));
            r.d = sram[8'(int'(b) + i)];
            r.l = (i == int'(n) - 1);
            exp_q.push_back(r);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; ready = 1'b1;
        #12;
        n_tests++;
        if ({cenb, wenb, valid, last, busy, done} !== 6'b110000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 110000", {cenb, wenb, valid, last, busy, done});
        end
        n_tests++;
        if (addr !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_addr: got %0d want 0", addr);
        end
        @(posedge clk); #2;
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        int first_v = -1, last_acc = -1, done_cyc = -1, n_done = 0, acc = 0;
        logic busy_c1 = 1'b0, busy_dn = 1'b1;
        launch(8'd0, 9'd4);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (valid && first_v < 0) first_v = k;
            if (valid && ready) acc++;
            if (valid && ready && last) last_acc = k;
            if (done) begin n_done++; done_cyc = k; busy_dn = busy; end
            if (k == 1) busy_c1 = busy;
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        n_tests++; if (first_v != 3) begin n_fail++; $display("FAIL basic_first_valid: got %0d want 3", first_v); end
        n_tests++; if (last_acc != 6) begin n_fail++; $display("FAIL basic_last_cycle: got %0d want 6", last_acc); end
        n_tests++; if (acc != 4) begin n_fail++; $display("FAIL basic_rows: got %0d want 4", acc); end
        n_tests++; if (done_cyc != 7 || n_done != 1) begin n_fail++; $display("FAIL basic_done: got cycle %0d count %0d want 7 1", done_cyc, n_done); end
        n_tests++; if (busy_c1 !== 1'b1 || busy_dn !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got c1=%b at_done=%b want 1 0", busy_c1, busy_dn); end
    endtask

    task automatic test_wrap();
        int n_done = 0;
        launch(8'd254, 9'd4);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done) n_done++;
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        n_tests++;
        if (n_done != 1 || exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_complete: got done=%0d rows_left=%0d reads_left=%0d want 1 0 0",
                     n_done, exp_q.size(), exp_addr_q.size());
        end
    endtask

    task automatic test_backpressure();
        logic pat [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int n_done = 0, acc = 0;
        launch(8'd30, 9'd6);
        ready = pat[0];
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (valid && ready) acc++;
            if (done) n_done++;
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
            ready = pat[(k + 1) % 10];
        end
        ready = 1'b1;
        n_tests++; if (acc != 6) begin n_fail++; $display("FAIL bp_rows: got %0d want 6", acc); end
        n_tests++;
        if (n_done != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_done: got done=%0d rows_left=%0d want 1 0", n_done, exp_q.size());
        end
    endtask

    task automatic test_zero();
        int n_cenb = 0, n_valid = 0, n_busy = 0, done_cyc = -1, n_done = 0;
        logic busy_c1 = 1'b0;
        launch(8'd5, 9'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!cenb) n_cenb++;
            if (valid) n_valid++;
            if (busy) n_busy++;
            if (k == 1) busy_c1 = busy;
            if (done) begin n_done++; done_cyc = k; end
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        n_tests++; if (n_cenb != 0 || n_valid != 0) begin n_fail++; $display("FAIL zero_activity: got reads=%0d valids=%0d want 0 0", n_cenb, n_valid); end
        n_tests++; if (n_busy != 1 || busy_c1 !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got cycles=%0d c1=%b want 1 1", n_busy, busy_c1); end
        n_tests++; if (done_cyc != 2 || n_done != 1) begin n_fail++; $display("FAIL zero_done: got cycle %0d count %0d want 2 1", done_cyc, n_done); end
    endtask

    task automatic test_start_held();
        int n_done = 0, late_reads = 0, late_busy = 0;
        launch(8'd20, 9'd5);
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (n_done > 0 && !cenb) late_reads++;
            if (n_done > 0 && busy) late_busy++;
            if (done) n_done++;
            @(posedge clk); #1;
            if (k == 2) start = 1'b0;
            if (k == 3) start = 1'b1;
        end
        n_tests++; if (n_done != 1) begin n_fail++; $display("FAIL held_done: got %0d want 1", n_done); end
        n_tests++; if (late_reads != 0 || late_busy != 0) begin n_fail++; $display("FAIL held_relaunch: got reads=%0d busy=%0d want 0 0", late_reads, late_busy); end
        start = 1'b0;
        n_done = 0;
        launch(8'd40, 9'd2);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) n_done++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_tests++;
        if (n_done != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL held_second: got done=%0d rows_left=%0d want 1 0", n_done, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0, n_done = 0, first_v = -1;
        logic hit = 1'b0;
        launch(8'd10, 9'd5);
        for (int k = 0; k < 20 && !hit; k++) begin
            @(negedge clk);
            if (valid && ready) acc++;
            if (done) n_done++;
            if (acc == 2) hit = 1'b1;
            else begin
                @(posedge clk); #1;
                if (k == 0) start = 1'b0;
            end
        end
        n_tests++; if (!hit) begin n_fail++; $display("FAIL rst_wait: got %0d rows want 2 before timeout", acc); end
        #2 rstn = 1'b0;
        #1;
        n_tests++;
        if ({cenb, wenb, valid, last, busy, done} !== 6'b110000 || addr !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: got %b addr=%0d want 110000 addr=0",
                     {cenb, wenb, valid, last, busy, done}, addr);
        end
        exp_q.delete();
        exp_addr_q.delete();
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) n_done++;
        end
        @(posedge clk); #2;
        rstn = 1'b1;
        n_tests++; if (n_done != 0) begin n_fail++; $display("FAIL rst_no_done: got %0d want 0", n_done); end
        launch(8'd100, 9'd3);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (valid && first_v < 0) first_v = k;
            if (done) n_done++;
            @(posedge clk); #1;
            if (k == 0) start = 1'b0;
        end
        n_tests++;
        if (first_v != 3 || n_done != 1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_relaunch: got first=%0d done=%0d rows_left=%0d want 3 1 0",
                     first_v, n_done, exp_q.size());
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++)
            sram[k] = {8'(k + 3), 8'(k + 2), 8'(k + 1), 8'(k)};
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero();
        test_start_held();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
